fetch_unit: RTL and testbench

Instruction fetch stage of the mycpu datapath, directly upstream of the instruction register. It holds the program counter (PC) and runs a single-outstanding request/acknowledge read on instruction memory. It delivers each fetched word on `ins_out` with a one-cycle `il_out` load strobe that drives the instruction register's load enable. It also applies signed relative branches using the immediate offset decoded from the current instruction.

---
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC and runs a single-outstanding
// request/acknowledge read on instruction memory. Each fetched word is handed
// to the instruction register with a one-cycle il_out load strobe.
// Optional feature: define FETCH_TIMEOUT_EN to abort a fetch that gets no ack
// within 15 wait cycles, pulsing err_out.
module fetch_unit #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req_in,
  input  logic        pc_rel_in,
  input  logic [15:0] ia_in,
  output logic        mem_req_out,
  output logic [15:0] mem_addr_out,
  input  logic [15:0] mem_rdata_in,
  input  logic        mem_ack_in,
  output logic [15:0] ins_out,
  output logic        il_out,
  output logic        busy_out,
  output logic [15:0] pc_out,
  output logic        err_out
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StLoad = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ins_q, ins_d;

`ifdef FETCH_TIMEOUT_EN
  logic [3:0]  wait_q, wait_d;
  logic        err_q, err_d;
`endif

  // Next-state, PC and instruction-latch logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
`ifdef FETCH_TIMEOUT_EN
    wait_d  = wait_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        // Branch and fetch may coincide; the fetch then sees the branched PC.
        if (pc_rel_in) begin
          pc_d = pc_q + ia_in;
        end
        if (fetch_req_in) begin
          state_d = StReq;
`ifdef FETCH_TIMEOUT_EN
          wait_d  = 4'd0;
`endif
        end
      end
      StReq: begin
        if (mem_ack_in) begin
          ins_d   = mem_rdata_in;
          pc_d    = pc_q + 16'd1;
          state_d = StLoad;
        end
`ifdef FETCH_TIMEOUT_EN
        // Count 14 means this is the 15th cycle without an ack.
        else if (wait_q == 4'd14) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 4'd1;
        end
`endif
      end
      StLoad: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers, asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= PC_RESET;
      ins_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Wait counter and one-cycle timeout error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= 4'd0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif

  // Outputs decode from state or come straight from registers only.
  assign mem_req_out  = (state_q == StReq);
  assign il_out       = (state_q == StLoad);
  assign busy_out     = (state_q == StReq) || (state_q == StLoad);
  assign mem_addr_out = pc_q;
  assign pc_out       = pc_q;
  assign ins_out      = ins_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: reset checks, a table of directed
// fetch/branch vectors, reset-mid-fetch, timeout behaviour, and a randomized
// run against a transaction-level PC/instruction model.
module tb_fetch_unit;

  localparam logic [15:0] PcRst = 16'h0010;

  logic        clk;
  logic        rst_n;
  logic        fetch_req_in;
  logic        pc_rel_in;
  logic [15:0] ia_in;
  logic        mem_req_out;
  logic [15:0] mem_addr_out;
  logic [15:0] mem_rdata_in;
  logic        mem_ack_in;
  logic [15:0] ins_out;
  logic        il_out;
  logic        busy_out;
  logic [15:0] pc_out;
  logic        err_out;

  int total = 0;
  int bad   = 0;

  fetch_unit #(
    .PC_RESET(PcRst)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req_in(fetch_req_in),
    .pc_rel_in   (pc_rel_in),
    .ia_in       (ia_in),
    .mem_req_out (mem_req_out),
    .mem_addr_out(mem_addr_out),
    .mem_rdata_in(mem_rdata_in),
    .mem_ack_in  (mem_ack_in),
    .ins_out     (ins_out),
    .il_out      (il_out),
    .busy_out    (busy_out),
    .pc_out      (pc_out),
    .err_out     (err_out)
  );

  always #5 clk = ~clk;

  // Memory contents: one fixed word at 0010, a simple pattern elsewhere.
  function automatic logic [15:0] memf(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hA5C3 : (a ^ 16'h5A5A);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issue one fetch from IDLE (optionally with a branch) and play memory with
  // the given number of wait states. Called and returns on a falling edge.
  task automatic fetch_txn(input logic rel, input logic [15:0] ia, input int waits,
                           input int bound, input bit noise,
                           output int req_n, output int il_n, output int err_n,
                           output int il_pos, output logic [15:0] addr,
                           output logic [15:0] ins, output logic [15:0] pc,
                           output bit expired);
    req_n = 0; il_n = 0; err_n = 0; il_pos = 0;
    addr = 16'h0; ins = 16'h0; pc = 16'h0; expired = 1'b1;
    fetch_req_in = 1'b1;
    pc_rel_in    = rel;
    ia_in        = ia;
    @(negedge clk);
    fetch_req_in = 1'b0;
    pc_rel_in    = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (il_out) begin
        il_n++;
        ins    = ins_out;
        pc     = pc_out;
        il_pos = i + 1;
      end
      if (err_out) err_n++;
      if (!busy_out) begin
        expired = 1'b0;
        break;
      end
      if (mem_req_out) begin
        req_n++;
        addr         = mem_addr_out;
        mem_rdata_in = memf(mem_addr_out);
        mem_ack_in   = (req_n > waits);
      end else begin
        mem_ack_in   = 1'b0;
        mem_rdata_in = 16'($urandom);
      end
      if (noise) begin
        fetch_req_in = 1'($urandom);
        pc_rel_in    = 1'($urandom);
        ia_in        = 16'($urandom);
      end
      @(negedge clk);
    end
    fetch_req_in = 1'b0;
    pc_rel_in    = 1'b0;
    mem_ack_in   = 1'b0;
  endtask

  task automatic branch_op(input logic [15:0] ia);
    pc_rel_in = 1'b1;
    ia_in     = ia;
    @(negedge clk);
    pc_rel_in = 1'b0;
  endtask

  typedef struct {
    logic        fetch;
    logic        rel;
    logic [15:0] ia;
    int          waits;
    logic [15:0] addr;
    logic [15:0] ins;
    logic [15:0] pc;
  } vec_t;

  vec_t vecs[10];

  int          req_n, il_n, err_n, il_pos;
  logic [15:0] got_addr, got_ins, got_pc;
  bit          expired;
  logic [15:0] m_pc, m_ins;

  // Drives all stimulus and checks.
  initial begin
    // fetch rel ia waits addr ins pc(after)
    vecs[0] = '{1'b1, 1'b0, 16'h0000, 0, 16'h0010, 16'hA5C3, 16'h0011};
    vecs[1] = '{1'b1, 1'b0, 16'h0000, 3, 16'h0011, 16'h5A4B, 16'h0012};
    vecs[2] = '{1'b0, 1'b1, 16'h000E, 0, 16'h0000, 16'h5A4B, 16'h0020};
    vecs[3] = '{1'b0, 1'b1, 16'hFFFC, 0, 16'h0000, 16'h5A4B, 16'h001C};
    vecs[4] = '{1'b1, 1'b1, 16'h0004, 0, 16'h0020, 16'h5A7A, 16'h0021};
    vecs[5] = '{1'b0, 1'b1, 16'hFFDE, 0, 16'h0000, 16'h5A7A, 16'hFFFF};
    vecs[6] = '{1'b1, 1'b0, 16'h0000, 1, 16'hFFFF, 16'hA5A5, 16'h0000};
    vecs[7] = '{1'b0, 1'b1, 16'hFFFF, 0, 16'h0000, 16'hA5A5, 16'hFFFF};
    vecs[8] = '{1'b0, 1'b1, 16'h0002, 0, 16'h0000, 16'hA5A5, 16'h0001};
    vecs[9] = '{1'b1, 1'b0, 16'h0000, 2, 16'h0001, 16'h5A5B, 16'h0002};

    clk = 1'b0; rst_n = 1'b0;
    fetch_req_in = 1'b0; pc_rel_in = 1'b0; ia_in = 16'h0;
    mem_rdata_in = 16'h0; mem_ack_in = 1'b0;
    repeat (2) @(negedge clk);
    check("reset pc", 32'(pc_out), 32'(PcRst));
    check("reset addr", 32'(mem_addr_out), 32'(PcRst));
    check("reset outs", {27'h0, mem_req_out, il_out, busy_out, err_out, |ins_out}, 32'h0);
    rst_n = 1'b1;

    // Spurious ack in IDLE has no effect.
    mem_ack_in = 1'b1; mem_rdata_in = 16'hBEEF;
    repeat (3) @(negedge clk);
    mem_ack_in = 1'b0;
    check("spurious ack state", {29'h0, il_out, busy_out, mem_req_out}, 32'h0);
    check("spurious ack ins", 32'(ins_out), 32'h0);
    check("spurious ack pc", 32'(pc_out), 32'(PcRst));

    // Directed table.
    foreach (vecs[i]) begin
      if (vecs[i].fetch) begin
        fetch_txn(vecs[i].rel, vecs[i].ia, vecs[i].waits, 40, 1'b0,
                  req_n, il_n, err_n, il_pos, got_addr, got_ins, got_pc, expired);
        check($sformatf("v%0d done", i), 32'(expired), 32'h0);
        check($sformatf("v%0d addr", i), 32'(got_addr), 32'(vecs[i].addr));
        check($sformatf("v%0d req cycles", i), 32'(req_n), 32'(vecs[i].waits + 1));
        check($sformatf("v%0d il count", i), 32'(il_n), 32'h1);
        check($sformatf("v%0d il latency", i), 32'(il_pos), 32'(vecs[i].waits + 2));
        check($sformatf("v%0d ins at il", i), 32'(got_ins), 32'(vecs[i].ins));
        check($sformatf("v%0d pc at il", i), 32'(got_pc), 32'(vecs[i].pc));
      end else begin
        branch_op(vecs[i].ia);
        check($sformatf("v%0d idle", i), 32'(busy_out), 32'h0);
      end
      check($sformatf("v%0d pc", i), 32'(pc_out), 32'(vecs[i].pc));
      check($sformatf("v%0d ins hold", i), 32'(ins_out), 32'(vecs[i].ins));
    end

    // Reset asserted mid-fetch drops the request without a clock edge.
    fetch_req_in = 1'b1;
    @(negedge clk);
    fetch_req_in = 1'b0;
    check("mid reset req before", 32'(mem_req_out), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid reset req async", {30'h0, mem_req_out, busy_out}, 32'h0);
    mem_ack_in = 1'b1; mem_rdata_in = 16'hBEEF;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_ack_in = 1'b0;
    @(negedge clk);
    check("late ack il", {30'h0, il_out, busy_out}, 32'h0);
    check("late ack ins", 32'(ins_out), 32'h0);
    check("late ack pc", 32'(pc_out), 32'(PcRst));
    m_pc = PcRst;
    m_ins = 16'h0;

`ifdef FETCH_TIMEOUT_EN
    fetch_txn(1'b0, 16'h0, 1000, 60, 1'b0,
              req_n, il_n, err_n, il_pos, got_addr, got_ins, got_pc, expired);
    check("timeout done", 32'(expired), 32'h0);
    check("timeout req cycles", 32'(req_n), 32'd15);
    check("timeout il", 32'(il_n), 32'h0);
    check("timeout err", 32'(err_n), 32'h1);
    check("timeout pc", 32'(pc_out), 32'(m_pc));
    check("timeout ins", 32'(ins_out), 32'(m_ins));
    @(negedge clk);
    check("timeout err one cycle", 32'(err_out), 32'h0);
    // An ack on the 15th wait cycle is still accepted.
    fetch_txn(1'b0, 16'h0, 14, 60, 1'b0,
              req_n, il_n, err_n, il_pos, got_addr, got_ins, got_pc, expired);
    check("late15 req cycles", 32'(req_n), 32'd15);
    check("late15 il", 32'(il_n), 32'h1);
    check("late15 err", 32'(err_n), 32'h0);
    check("late15 ins", 32'(got_ins), 32'(memf(m_pc)));
    m_ins = memf(m_pc);
    m_pc  = m_pc + 16'd1;
`else
    // No timeout: the request is still pending after 100 wait cycles.
    fetch_txn(1'b0, 16'h0, 101, 200, 1'b0,
              req_n, il_n, err_n, il_pos, got_addr, got_ins, got_pc, expired);
    check("no timeout done", 32'(expired), 32'h0);
    check("no timeout req cycles", 32'(req_n), 32'd102);
    check("no timeout err", 32'(err_n), 32'h0);
    check("no timeout il", 32'(il_n), 32'h1);
    m_ins = memf(m_pc);
    m_pc  = m_pc + 16'd1;
`endif

    // Random operations against a transaction-level model.
    for (int n = 0; n < 150; n++) begin
      int          op;
      int          w;
      logic [15:0] ia;
      op = int'($urandom_range(0, 2));
      w  = int'($urandom_range(0, 5));
      ia = 16'($urandom);
      if (op == 0) begin
        branch_op(ia);
        m_pc = m_pc + ia;
      end else begin
        if (op == 2) m_pc = m_pc + ia;
        fetch_txn(op == 2, ia, w, 40, 1'b1,
                  req_n, il_n, err_n, il_pos, got_addr, got_ins, got_pc, expired);
        check("rand addr", 32'(got_addr), 32'(m_pc));
        check("rand req cycles", 32'(req_n), 32'(w + 1));
        check("rand il", 32'(il_n), 32'h1);
        check("rand ins", 32'(got_ins), 32'(memf(m_pc)));
        m_ins = memf(m_pc);
        m_pc  = m_pc + 16'd1;
      end
      check("rand pc", 32'(pc_out), 32'(m_pc));
      check("rand ins hold", 32'(ins_out), 32'(m_ins));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
